ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single RAM port between the core DBus (port C) and a secondary master (port M: loader/DMA/debug).
//  Core has fixed priority; starvation counter forces a grant to M after MAX_WAIT stalled cycles.
//  Routes the 1-cycle-latency RAM read data back to the issuing port. Sits between core/dbus RAM outputs and RAM.
// PARAMETERS
//  ADDR_WIDTH   10   RAM word-address width (4kB default)
//  MAX_WAIT     4    consecutive stalled cycles of M before forced grant; legal range 1..255
// PORTS
//  clk            in   1           system clock
//  rst            in   1           synchronous reset, active-high
//  c_rd_en        in   1           core read request
//  c_wr_en        in   1           core write request
//  c_addr         in   ADDR_WIDTH  core word address
//  c_wr_data      in   32          core write data
//  c_wr_strobe    in   4           core byte strobes
//  c_gnt          out  1           core request accepted this cycle
//  c_rd_valid     out  1           core read data valid (cycle after grant)
//  c_rd_data      out  32          core read data
//  m_rd_en/m_wr_en/m_addr/m_wr_data/m_wr_strobe  in   as port C   secondary master request
//  m_gnt, m_rd_valid, m_rd_data  out  1/1/32      as port C
//  ram_rd_en      out  1           RAM read enable
//  ram_wr_en      out  1           RAM write enable
//  ram_addr       out  ADDR_WIDTH  RAM address
//  ram_wr_data    out  32          RAM write data
//  ram_wr_strobe  out  4           RAM byte strobes
//  ram_rd_data    in   32          RAM read data, valid 1 cycle after ram_rd_en
//  conflict_cnt   out  16          saturating count of cycles both ports requested
// BEHAVIOUR
//  - req_x = x_rd_en | x_wr_en. If both set on a port, treated as write only; no read return.
//  - Grant is combinational from requests + registered state; requester holds signals stable until gnt.
//  - States: PRIO_C (default), FORCE_M. At most one gnt per cycle; RAM outputs mux the granted port,
//    all RAM enables 0 when no grant (addr/data don't-care, driven from port C).
//  - PRIO_C: req_c -> c_gnt; else req_m -> m_gnt. wait_cnt (8b) +1 each cycle req_m & !m_gnt, saturating at MAX_WAIT.
//    When wait_cnt == MAX_WAIT at a clock edge -> next state FORCE_M.
//  - FORCE_M: req_m -> m_gnt regardless of req_c (c_gnt=0); then -> PRIO_C. If req_m dropped -> PRIO_C, no grant to M.
//  - wait_cnt cleared on m_gnt or when req_m=0.
//  - Read return: on granted read, register owner tag + valid; next cycle assert owner's x_rd_valid for exactly 1 cycle.
//    c_rd_data = m_rd_data = ram_rd_data unconditionally; only x_rd_valid qualifies.
//  - Back-to-back grants allowed every cycle; return tag pipelines so reads on consecutive cycles alternate correctly.
//  - conflict_cnt +1 each cycle req_c & req_m; saturates at 16'hFFFF.
//  - Reset: state=PRIO_C, wait_cnt=0, tag valid=0, conflict_cnt=0; during rst all gnt, rd_valid, ram_rd_en, ram_wr_en = 0.
//    Reset mid-read drops the pending return (no rd_valid the cycle after reset).
//  - Max M latency with continuous core traffic: MAX_WAIT+1 cycles from req_m to m_gnt.
// TESTING
//  1. C read 0x010 alone -> c_gnt same cycle, ram_rd_en=1 addr 0x010; next cycle c_rd_valid=1, data=RAM[0x010], m_rd_valid=0.
//  2. C and M both request continuously, MAX_WAIT=4 -> C granted cycles 0-3, M granted cycle 4, C resumes cycle 5; conflict_cnt=5 after 5 cycles.
//  3. M write 0xDEADBEEF strobe 4'b0011 @0x3FF, C idle -> m_gnt same cycle, ram_wr_en=1, strobe 0011; no rd_valid.
//  4. C read @1 then M read @2 back-to-back -> c_rd_valid cycle 1 with RAM[1], m_rd_valid cycle 2 with RAM[2].
//  5. M reaches FORCE_M then drops req -> no m_gnt, state PRIO_C, wait_cnt=0; rst asserted after a granted read -> no rd_valid, counters 0.
//  6. rd_en & wr_en both on C -> write performed, c_rd_valid stays 0; conflict_cnt held at 16'hFFFF saturates.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the core (C) and a secondary master (M).
// C has fixed priority; a starvation counter forces an M grant after MAX_WAIT stalls.
module ram_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c_rd_en,
   input  logic                  c_wr_en,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [31:0]           c_wr_data,
   input  logic [3:0]            c_wr_strobe,
   output logic                  c_gnt,
   output logic                  c_rd_valid,
   output logic [31:0]           c_rd_data,
   input  logic                  m_rd_en,
   input  logic                  m_wr_en,
   input  logic [ADDR_WIDTH-1:0] m_addr,
   input  logic [31:0]           m_wr_data,
   input  logic [3:0]            m_wr_strobe,
   output logic                  m_gnt,
   output logic                  m_rd_valid,
   output logic [31:0]           m_rd_data,
   output logic                  ram_rd_en,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wr_data,
   output logic [3:0]            ram_wr_strobe,
   input  logic [31:0]           ram_rd_data,
   output logic [15:0]           conflict_cnt
);

   typedef enum logic {
      PRIO_C,
      FORCE_M
   } state_t;

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   state_t     state, state_next;
   logic [7:0] wait_cnt, wait_next;
   logic       req_c, req_m;
   logic       tag_valid, tag_m;

   assign req_c = c_rd_en | c_wr_en;
   assign req_m = m_rd_en | m_wr_en;

   always_comb begin
      c_gnt      = 1'b0;
      m_gnt      = 1'b0;
      state_next = state;
      wait_next  = wait_cnt;
      if (!rst) begin
         unique case (state)
            PRIO_C: begin
               if (req_c)      c_gnt = 1'b1;
               else if (req_m) m_gnt = 1'b1;
            end
            FORCE_M: begin
               // The forced slot is M's; C only uses it if M has withdrawn.
               if (req_m)      m_gnt = 1'b1;
               else if (req_c) c_gnt = 1'b1;
               state_next = PRIO_C;
            end
            default: state_next = PRIO_C;
         endcase
         if (!req_m || m_gnt)
            wait_next = '0;
         else if (wait_cnt < MAX_W)
            wait_next = wait_cnt + 8'd1;
         // Entering FORCE_M as the counter reaches MAX_WAIT bounds M latency to MAX_WAIT+1.
         if (state == PRIO_C && wait_next == MAX_W)
            state_next = FORCE_M;
      end
   end

   always_comb begin
      ram_addr      = m_gnt ? m_addr      : c_addr;
      ram_wr_data   = m_gnt ? m_wr_data   : c_wr_data;
      ram_wr_strobe = m_gnt ? m_wr_strobe : c_wr_strobe;
      ram_wr_en     = (c_gnt & c_wr_en) | (m_gnt & m_wr_en);
      ram_rd_en     = (c_gnt & c_rd_en & ~c_wr_en) | (m_gnt & m_rd_en & ~m_wr_en);
   end

   assign c_rd_valid = tag_valid & ~tag_m & ~rst;
   assign m_rd_valid = tag_valid &  tag_m & ~rst;
   assign c_rd_data  = ram_rd_data;
   assign m_rd_data  = ram_rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= PRIO_C;
         wait_cnt     <= '0;
         tag_valid    <= 1'b0;
         tag_m        <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         state     <= state_next;
         wait_cnt  <= wait_next;
         tag_valid <= ram_rd_en;
         tag_m     <= m_gnt;
         if (req_c && req_m && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural 1-cycle RAM.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_rd_en, c_wr_en, m_rd_en, m_wr_en;
   logic [9:0]  c_addr, m_addr, ram_addr;
   logic [31:0] c_wr_data, m_wr_data, ram_wr_data;
   logic [3:0]  c_wr_strobe, m_wr_strobe, ram_wr_strobe;
   logic        c_gnt, c_rd_valid, m_gnt, m_rd_valid;
   logic [31:0] c_rd_data, m_rd_data;
   logic        ram_rd_en, ram_wr_en;
   logic [31:0] ram_rd_data;
   logic [15:0] conflict_cnt;

   int assertions = 0;
   int failures   = 0;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_WIDTH(10), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .c_rd_en(c_rd_en), .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wr_data(c_wr_data),
      .c_wr_strobe(c_wr_strobe), .c_gnt(c_gnt), .c_rd_valid(c_rd_valid), .c_rd_data(c_rd_data),
      .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wr_data(m_wr_data),
      .m_wr_strobe(m_wr_strobe), .m_gnt(m_gnt), .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data),
      .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
      .ram_wr_data(ram_wr_data), .ram_wr_strobe(ram_wr_strobe), .ram_rd_data(ram_rd_data),
      .conflict_cnt(conflict_cnt)
   );

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
   end

   always @(posedge clk) begin
      if (ram_wr_en)
         for (int b = 0; b < 4; b++)
            if (ram_wr_strobe[b]) mem[ram_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
      if (ram_rd_en) ram_rd_data <= mem[ram_addr];
   end

   // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      c_rd_en = 0; c_wr_en = 0; c_addr = '0; c_wr_data = '0; c_wr_strobe = '0;
      m_rd_en = 0; m_wr_en = 0; m_addr = '0; m_wr_data = '0; m_wr_strobe = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step();
      c_rd_en = 1; m_wr_en = 1;
      #4;
      assertions++;
      if ({c_gnt, m_gnt, ram_rd_en, ram_wr_en, c_rd_valid, m_rd_valid} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {c_gnt, m_gnt, ram_rd_en, ram_wr_en, c_rd_valid, m_rd_valid});
      end
      step();
      assertions++;
      if (conflict_cnt !== 16'h0) begin
         failures++;
         $display("FAIL reset_conflict: got %h expected 0000", conflict_cnt);
      end
      rst = 1'b0;
      idle();
      step();
   endtask

   task automatic test_core_read();
      do_reset();
      c_rd_en = 1; c_addr = 10'h010;
      #4;
      assertions++;
      if ({c_gnt, m_gnt, ram_rd_en, ram_wr_en} !== 4'b1010 || ram_addr !== 10'h010) begin
         failures++;
         $display("FAIL core_read_grant: gnt/rd/wr %b addr %h expected 1010 addr 010",
                  {c_gnt, m_gnt, ram_rd_en, ram_wr_en}, ram_addr);
      end
      step();
      idle();
      #4;
      assertions++;
      if (c_rd_valid !== 1'b1 || m_rd_valid !== 1'b0 || c_rd_data !== 32'hC0DE0010) begin
         failures++;
         $display("FAIL core_read_return: c_v %b m_v %b data %h expected 1 0 c0de0010",
                  c_rd_valid, m_rd_valid, c_rd_data);
      end
      step();
      #4;
      assertions++;
      if (c_rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL core_read_single: c_rd_valid %b expected 0", c_rd_valid);
      end
   endtask

   task automatic test_starvation();
      do_reset();
      c_wr_en = 1; c_addr = 10'h100; c_wr_strobe = 4'hF; c_wr_data = 32'h11111111;
      m_wr_en = 1; m_addr = 10'h101; m_wr_strobe = 4'hF; m_wr_data = 32'h22222222;
      for (int k = 0; k < 6; k++) begin
         #4;
         assertions++;
         if (c_gnt !== (k != 4) || m_gnt !== (k == 4)) begin
            failures++;
            $display("FAIL starve_cycle%0d: c_gnt %b m_gnt %b expected %b %b",
                     k, c_gnt, m_gnt, k != 4, k == 4);
         end
         if (k == 4) begin
            assertions++;
            if (ram_addr !== 10'h101 || ram_wr_data !== 32'h22222222) begin
               failures++;
               $display("FAIL starve_mux: addr %h data %h expected 101 22222222", ram_addr, ram_wr_data);
            end
         end
         if (k == 5) begin
            assertions++;
            if (conflict_cnt !== 16'd5) begin
               failures++;
               $display("FAIL starve_conflict: got %0d expected 5", conflict_cnt);
            end
         end
         step();
      end
      idle();
   endtask

   task automatic test_m_write();
      do_reset();
      m_wr_en = 1; m_addr = 10'h3FF; m_wr_data = 32'hDEADBEEF; m_wr_strobe = 4'b0011;
      #4;
      assertions++;
      if ({c_gnt, m_gnt, ram_rd_en, ram_wr_en} !== 4'b0101 || ram_wr_strobe !== 4'b0011 ||
          ram_addr !== 10'h3FF || ram_wr_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL m_write: gnt/rd/wr %b strb %b addr %h data %h expected 0101 0011 3ff deadbeef",
                  {c_gnt, m_gnt, ram_rd_en, ram_wr_en}, ram_wr_strobe, ram_addr, ram_wr_data);
      end
      step();
      idle();
      c_rd_en = 1; c_addr = 10'h3FF;
      #4;
      assertions++;
      if (c_rd_valid !== 1'b0 || m_rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL m_write_no_valid: c_v %b m_v %b expected 0 0", c_rd_valid, m_rd_valid);
      end
      step();
      idle();
      #4;
      assertions++;
      if (c_rd_valid !== 1'b1 || c_rd_data !== 32'hC0DEBEEF) begin
         failures++;
         $display("FAIL m_write_readback: v %b data %h expected 1 c0debeef", c_rd_valid, c_rd_data);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      c_rd_en = 1; c_addr = 10'h001;
      #4;
      assertions++;
      if (c_gnt !== 1'b1) begin
         failures++;
         $display("FAIL b2b_c_gnt: got %b expected 1", c_gnt);
      end
      step();
      idle();
      m_rd_en = 1; m_addr = 10'h002;
      #4;
      assertions++;
      if (m_gnt !== 1'b1 || c_rd_valid !== 1'b1 || m_rd_valid !== 1'b0 || c_rd_data !== 32'hC0DE0001) begin
         failures++;
         $display("FAIL b2b_cycle1: m_gnt %b c_v %b m_v %b data %h expected 1 1 0 c0de0001",
                  m_gnt, c_rd_valid, m_rd_valid, c_rd_data);
      end
      step();
      idle();
      #4;
      assertions++;
      if (m_rd_valid !== 1'b1 || c_rd_valid !== 1'b0 || m_rd_data !== 32'hC0DE0002) begin
         failures++;
         $display("FAIL b2b_cycle2: m_v %b c_v %b data %h expected 1 0 c0de0002",
                  m_rd_valid, c_rd_valid, m_rd_data);
      end
   endtask

   task automatic test_force_drop_and_reset();
      do_reset();
      c_wr_en = 1; c_addr = 10'h200; c_wr_strobe = 4'hF; c_wr_data = 32'h33333333;
      m_rd_en = 1; m_addr = 10'h201;
      repeat (4) step();
      m_rd_en = 0;
      #4;
      assertions++;
      if (m_gnt !== 1'b0 || m_rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL force_drop: m_gnt %b m_v %b expected 0 0", m_gnt, m_rd_valid);
      end
      step();
      m_rd_en = 1;
      #4;
      assertions++;
      if (dut.wait_cnt !== 8'd0 || dut.state !== dut.PRIO_C) begin
         failures++;
         $display("FAIL force_drop_state: wait_cnt %0d state %0d expected 0 0", dut.wait_cnt, dut.state);
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) #4;
         assertions++;
         if (m_gnt !== (k == 4)) begin
            failures++;
            $display("FAIL force_restart%0d: m_gnt %b expected %b", k, m_gnt, k == 4);
         end
         step();
      end
      idle();
      c_rd_en = 1; c_addr = 10'h005;
      m_wr_en = 1;
      step();
      rst = 1'b1;
      #4;
      assertions++;
      if (c_rd_valid !== 1'b0 || c_gnt !== 1'b0 || m_gnt !== 1'b0) begin
         failures++;
         $display("FAIL reset_midread: c_v %b c_gnt %b m_gnt %b expected 0 0 0", c_rd_valid, c_gnt, m_gnt);
      end
      step();
      rst = 1'b0;
      idle();
      #4;
      assertions++;
      if (c_rd_valid !== 1'b0 || conflict_cnt !== 16'h0 || dut.wait_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_after: c_v %b conflict %h wait %0d expected 0 0000 0",
                  c_rd_valid, conflict_cnt, dut.wait_cnt);
      end
   endtask

   task automatic test_rdwr_and_saturation();
      do_reset();
      c_rd_en = 1; c_wr_en = 1; c_addr = 10'h020; c_wr_data = 32'h12345678; c_wr_strobe = 4'hF;
      #4;
      assertions++;
      if ({c_gnt, ram_rd_en, ram_wr_en} !== 3'b101 || ram_wr_data !== 32'h12345678) begin
         failures++;
         $display("FAIL rdwr_grant: gnt/rd/wr %b data %h expected 101 12345678",
                  {c_gnt, ram_rd_en, ram_wr_en}, ram_wr_data);
      end
      step();
      idle();
      c_rd_en = 1; c_addr = 10'h020;
      #4;
      assertions++;
      if (c_rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL rdwr_no_valid: c_rd_valid %b expected 0", c_rd_valid);
      end
      step();
      idle();
      #4;
      assertions++;
      if (c_rd_valid !== 1'b1 || c_rd_data !== 32'h12345678) begin
         failures++;
         $display("FAIL rdwr_readback: v %b data %h expected 1 12345678", c_rd_valid, c_rd_data);
      end
      do_reset();
      c_wr_en = 1; c_addr = 10'h300; c_wr_strobe = 4'h0;
      m_wr_en = 1; m_addr = 10'h301; m_wr_strobe = 4'h0;
      repeat (65534) @(posedge clk);
      #5;
      assertions++;
      if (conflict_cnt !== 16'hFFFE) begin
         failures++;
         $display("FAIL conflict_pre_sat: got %h expected fffe", conflict_cnt);
      end
      repeat (5) @(posedge clk);
      #5;
      assertions++;
      if (conflict_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL conflict_sat: got %h expected ffff", conflict_cnt);
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_core_read();
      test_starvation();
      test_m_write();
      test_back_to_back();
      test_force_drop_and_reset();
      test_rdwr_and_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
